// File: rtl/sid_osc_bank.sv
// SID-style oscillator bank: VOICES voices share one accumulator and waveform
// datapath, processed one voice per clock after each ce_1m round-start strobe.
module sid_osc_bank #(
   parameter int VOICES = 3,
   parameter int ACC_W  = 24,
   parameter int FREQ_W = 16,
   parameter int PW_W   = 12,
   parameter int WAVE_W = 12,
   parameter int LFSR_W = 23,
   localparam int IDX_W = $clog2(VOICES)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              ce_1m,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_voice,
   input  logic [1:0]        wr_sel,
   input  logic [15:0]       wr_data,
   output logic              wave_valid,
   output logic [IDX_W-1:0]  wave_voice,
   output logic [WAVE_W-1:0] wave_data,
   output logic [VOICES-1:0] gate,
   output logic [VOICES-1:0] osc_msb,
   output logic              busy,
   output logic              overrun
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [VOICES-1:0]  snap_prv;
   logic [VOICES-1:0]  snap_cur;
   logic [VOICES-1:0]  test_d;

   logic [ACC_W-1:0]   acc       [VOICES];
   logic [LFSR_W-1:0]  lfsr      [VOICES];
   logic [FREQ_W-1:0]  freq      [VOICES];
   logic [PW_W-1:0]    pw        [VOICES];
   logic [7:0]         ctl       [VOICES];
   logic [WAVE_W-1:0]  last_wave [VOICES];

   // Datapath for the voice selected by idx
   logic [IDX_W-1:0]   src;
   logic [ACC_W-1:0]   cur_acc;
   logic [ACC_W-1:0]   nxt_acc;
   logic [LFSR_W-1:0]  cur_lfsr;
   logic [LFSR_W-1:0]  nxt_lfsr;
   logic [7:0]         cur_ctl;
   logic               test;
   logic               m;
   logic [WAVE_W-1:0]  tri_w;
   logic [WAVE_W-1:0]  saw_w;
   logic [WAVE_W-1:0]  pul_w;
   logic [WAVE_W-1:0]  noi_w;
   logic [WAVE_W-1:0]  wave;
   logic               wr_ok;

   always_comb begin
      src      = (idx == '0) ? IDX_W'(VOICES - 1) : idx - IDX_W'(1);
      cur_acc  = acc[idx];
      cur_lfsr = lfsr[idx];
      cur_ctl  = ctl[idx];
      test     = cur_ctl[3];

      if (test || test_d[idx] || (cur_ctl[1] && snap_prv[src] && !snap_cur[src]))
         nxt_acc = '0;
      else
         nxt_acc = cur_acc + ACC_W'(freq[idx]);

      // Noise clocks on a rising edge of the tap bit across this round's update
      if (test)
         nxt_lfsr = '1;
      else if (!cur_acc[ACC_W-5] && nxt_acc[ACC_W-5])
         nxt_lfsr = {cur_lfsr[LFSR_W-2:0], cur_lfsr[LFSR_W-1] ^ cur_lfsr[LFSR_W-6]};
      else
         nxt_lfsr = cur_lfsr;

      m     = cur_acc[ACC_W-1] ^ (cur_ctl[2] & ~snap_cur[src]);
      tri_w = {WAVE_W{m}} ^ cur_acc[ACC_W-2 -: WAVE_W];
      saw_w = cur_acc[ACC_W-1 -: WAVE_W];
      pul_w = {WAVE_W{test || (cur_acc[ACC_W-1 -: PW_W] >= pw[idx])}};
      noi_w = cur_lfsr[LFSR_W-1 -: WAVE_W];

      wave = '1;
      if (cur_ctl[4]) wave = wave & tri_w;
      if (cur_ctl[5]) wave = wave & saw_w;
      if (cur_ctl[6]) wave = wave & pul_w;
      if (cur_ctl[7]) wave = wave & noi_w;
      if (cur_ctl[7:4] == 4'b0000) wave = last_wave[idx];

      wr_ok = wr_en && (int'(wr_voice) < VOICES);
   end

   always_comb begin
      gate    = '0;
      osc_msb = '0;
      for (int v = 0; v < VOICES; v++) begin
         gate[v]    = ctl[v][0];
         osc_msb[v] = acc[v][ACC_W-1];
      end
   end

   // NOTE: the per-voice register arrays are reset like any other state so that
   // a mid-round reset leaves no stale phase, noise or held sample behind; all
   // state here uses non-blocking assignments so every read sees pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         idx        <= '0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
         wave_valid <= 1'b0;
         wave_voice <= '0;
         wave_data  <= '0;
         snap_prv   <= '0;
         snap_cur   <= '0;
         test_d     <= '0;
         for (int v = 0; v < VOICES; v++) begin
            acc[v]       <= '0;
            lfsr[v]      <= '1;
            freq[v]      <= '0;
            pw[v]        <= '0;
            ctl[v]       <= '0;
            last_wave[v] <= '0;
         end
      end else begin
         wave_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (ce_1m) begin
                  state    <= RUN;
                  idx      <= '0;
                  busy     <= 1'b1;
                  snap_prv <= snap_cur;
                  snap_cur <= osc_msb;
               end
            end
            RUN: begin
               if (ce_1m) overrun <= 1'b1;
               acc[idx]       <= nxt_acc;
               lfsr[idx]      <= nxt_lfsr;
               test_d[idx]    <= test;
               last_wave[idx] <= wave;
               wave_valid     <= 1'b1;
               wave_voice     <= idx;
               wave_data      <= wave;
               if (idx == IDX_W'(VOICES - 1))
                  state <= DONE;
               else
                  idx <= idx + IDX_W'(1);
            end
            DONE: begin
               // Last sample is on the output this cycle; still counts as busy
               if (ce_1m) overrun <= 1'b1;
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase

         if (wr_ok) begin
            case (wr_sel)
               2'd0:    freq[wr_voice] <= wr_data[FREQ_W-1:0];
               2'd1:    pw[wr_voice]   <= wr_data[PW_W-1:0];
               2'd2:    ctl[wr_voice]  <= wr_data[7:0];
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sid_osc_bank.sv
// Scoreboard bench for sid_osc_bank: stimulus pushes hand-computed samples,
// a negedge monitor pops and compares every wave_valid beat (data, voice, cycle).
module tb_sid_osc_bank;

   localparam int VOICES = 3;

   logic        clock    = 1'b0;
   logic        reset_n  = 1'b0;
   logic        ce_1m    = 1'b0;
   logic        wr_en    = 1'b0;
   logic [1:0]  wr_voice = '0;
   logic [1:0]  wr_sel   = '0;
   logic [15:0] wr_data  = '0;
   logic        wave_valid;
   logic [1:0]  wave_voice;
   logic [11:0] wave_data;
   logic [2:0]  gate;
   logic [2:0]  osc_msb;
   logic        busy;
   logic        overrun;

   typedef struct {
      logic [1:0]  voice;
      logic [11:0] data;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   passes = 0;

   sid_osc_bank dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .ce_1m      (ce_1m),
      .wr_en      (wr_en),
      .wr_voice   (wr_voice),
      .wr_sel     (wr_sel),
      .wr_data    (wr_data),
      .wave_valid (wave_valid),
      .wave_voice (wave_voice),
      .wave_data  (wave_data),
      .gate       (gate),
      .osc_msb    (osc_msb),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor
   always @(negedge clock) begin
      exp_t e;
      if (reset_n && wave_valid) begin
         if (sb.size() == 0) begin
            check("unexpected wave_valid", 32'(wave_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            check($sformatf("v%0d wave_data", e.voice), 32'(wave_data), 32'(e.data));
            check($sformatf("v%0d wave_voice", e.voice), 32'(wave_voice), 32'(e.voice));
            check($sformatf("v%0d output cycle", e.voice), 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic push_round(input logic [11:0] e0, input logic [11:0] e1,
                             input logic [11:0] e2, input int c0);
      logic [11:0] ev [VOICES];
      ev = '{e0, e1, e2};
      for (int i = 0; i < VOICES; i++)
         sb.push_back('{voice: 2'(i), data: ev[i], cyc: c0 + 2 + i});
   endtask

   task automatic run_round(input logic [11:0] e0, input logic [11:0] e1, input logic [11:0] e2,
                            input logic do_wr, input logic [1:0] wv, input logic [1:0] ws,
                            input logic [15:0] wd);
      push_round(e0, e1, e2, cyc);
      ce_1m = 1'b1;
      @(negedge clock);
      ce_1m = 1'b0;
      for (int off = 1; off <= VOICES + 1; off++) begin
         check($sformatf("busy cycle %0d", off), 32'(busy), 32'd1);
         if (do_wr && off == 2) begin
            wr_voice = wv; wr_sel = ws; wr_data = wd; wr_en = 1'b1;
         end
         @(negedge clock);
         wr_en = 1'b0;
      end
      check("busy after round", 32'(busy), 32'd0);
   endtask

   task automatic round(input logic [11:0] e0, input logic [11:0] e1, input logic [11:0] e2);
      run_round(e0, e1, e2, 1'b0, 2'd0, 2'd0, 16'h0);
   endtask

   task automatic wr(input logic [1:0] v, input logic [1:0] s, input logic [15:0] d);
      wr_voice = v; wr_sel = s; wr_data = d; wr_en = 1'b1;
      @(negedge clock);
      wr_en = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      repeat (2) @(negedge clock);
      check("reset wave_valid", 32'(wave_valid), 32'd0);
      check("reset wave_data", 32'(wave_data), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset overrun", 32'(overrun), 32'd0);
      check("reset gate", 32'(gate), 32'd0);
      check("reset osc_msb", 32'(osc_msb), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // Saw on v0, ring-modulated triangle on v1, tri&saw on v2
      wr(0, 0, 16'h1000); wr(0, 2, 16'h0021);
      wr(1, 0, 16'h1000); wr(1, 2, 16'h0014);
      wr(2, 0, 16'h1000); wr(2, 2, 16'h0030);
      check("gate after ctl write", 32'(gate), 32'h1);
      for (int k = 0; k < 17; k++) begin
         logic [11:0] s;
         logic [11:0] t;
         s = 12'(k);
         t = 12'(2 * k);
         round(s, 12'hFFF ^ t, s & t);
      end
      check("overrun after spaced rounds", 32'(overrun), 32'd0);

      // Test bit forces pulse high and holds acc; noise reads all-ones lfsr
      do_reset();
      wr(1, 0, 16'h4000); wr(1, 1, 16'h0FFF); wr(1, 2, 16'h0048);
      round(0, 12'hFFF, 0);
      round(0, 12'hFFF, 0);
      wr(1, 2, 16'h0080);
      round(0, 12'hFFF, 0);
      round(0, 12'hFFF, 0);
      wr(1, 2, 16'h0040); wr(1, 1, 16'h0008);
      round(0, 12'h000, 0);
      round(0, 12'hFFF, 0);
      wr(1, 2, 16'h0000);
      round(0, 12'hFFF, 0);

      // Hard sync of v0 on a falling v2 msb
      do_reset();
      wr(2, 0, 16'hFFFF);
      for (int k = 0; k < 128; k++) round(0, 0, 0);
      check("osc_msb before v2 wrap", 32'(osc_msb), 32'h0);
      round(0, 0, 0);
      check("osc_msb after v2 msb set", 32'(osc_msb), 32'h4);
      wr(0, 0, 16'h1000); wr(0, 2, 16'h0022); wr(2, 2, 16'h0008);
      round(0, 0, 0);
      wr(2, 2, 16'h0000);
      round(12'h001, 0, 0);
      round(12'h000, 0, 0);
      round(12'h001, 0, 0);

      // Write to the voice being processed lands next round
      do_reset();
      wr(1, 0, 16'h1000); wr(1, 2, 16'h0020);
      run_round(0, 0, 0, 1'b1, 2'd1, 2'd0, 16'h2000);
      round(0, 12'h001, 0);
      round(0, 12'h003, 0);

      // ce_1m during a round is dropped and flags overrun
      do_reset();
      c0 = cyc;
      push_round(0, 0, 0, c0);
      ce_1m = 1'b1;
      @(negedge clock);
      ce_1m = 1'b0;
      @(negedge clock);
      ce_1m = 1'b1;
      @(negedge clock);
      ce_1m = 1'b0;
      repeat (5) @(negedge clock);
      check("overrun after early ce_1m", 32'(overrun), 32'd1);
      round(0, 0, 0);
      check("overrun stays set", 32'(overrun), 32'd1);

      // Reset in cycle 2 aborts the round
      wr(0, 0, 16'h1000); wr(0, 2, 16'h0021);
      round(12'h000, 0, 0);
      round(12'h001, 0, 0);
      ce_1m = 1'b1;
      @(negedge clock);
      ce_1m = 1'b0;
      @(posedge clock);
      #1 reset_n = 1'b0;
      #1;
      check("abort wave_valid", 32'(wave_valid), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      check("abort overrun", 32'(overrun), 32'd0);
      check("abort gate", 32'(gate), 32'd0);
      check("abort wave_data", 32'(wave_data), 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      wr(0, 0, 16'h1000); wr(0, 2, 16'h0020);
      round(12'h000, 0, 0);
      round(12'h001, 0, 0);

      repeat (3) @(negedge clock);
      check("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
